// File: rtl/case10_resp_pkg.sv
// Shared types and default parameters for the case10 response-compaction stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package case10_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          DEF_SIG_W   = 16;
    localparam logic [15:0] DEF_POLY    = 16'h1021;
    localparam logic [15:0] DEF_SEED    = 16'hFFFF;
    localparam int          DEF_CNT_W   = 8;
    localparam int          DEF_NUM_VEC = 16;

endpackage

// File: rtl/case10_misr_core.sv
// Registered MISR: shifts left, XORs POLY when the MSB falls out, folds din into the low bits.
// Latency: 1 cycle from en to updated sig; load takes priority over en.
// Backpressure: none; caller gates en with its own handshake.
module case10_misr_core
    import case10_resp_pkg::*;
#(
    parameter int               SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [1:0]       din,
    input  logic [SIG_W-1:0] seed,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_next;

    // One MISR step: shift, conditional polynomial feedback, inject the 2-bit response.
    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-2){1'b0}}, din};
    end

    // Signature register; reset and load both restart from the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= seed;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/case10_resp_misr.sv
// Compacts NUM_VEC (y1,y2) responses into a MISR signature and compares it with exp_sig.
// Latency: signature updates 1 cycle after accept; done/pass 2 cycles after the last accept.
// Backpressure: in_ready only in RUN; in_valid elsewhere is dropped. Optional RESP_TOGGLE_CNT_EN adds tog_y1/tog_y2.
module case10_resp_misr
    import case10_resp_pkg::*;
#(
    parameter int               SIG_W   = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED),
    parameter int               CNT_W   = DEF_CNT_W,
    parameter int               NUM_VEC = DEF_NUM_VEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             y1,
    input  logic             y2,
    input  logic [SIG_W-1:0] exp_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] vec_cnt
`ifdef RESP_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] tog_y1,
    output logic [CNT_W-1:0] tog_y2
`endif
);

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   start_ok;
    logic   last_beat;

    assign accept    = in_valid & in_ready;
    assign start_ok  = start & ((state_q == IDLE) | (state_q == DONE));
    assign last_beat = accept & (vec_cnt == CNT_W'(NUM_VEC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: CHECK always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok)  state_d = RUN;
            RUN:     if (last_beat) state_d = CHECK;
            CHECK:                  state_d = DONE;
            DONE:    if (start_ok)  state_d = RUN;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        in_ready = (state_q == RUN);
        busy     = (state_q == RUN) | (state_q == CHECK);
        done     = (state_q == DONE);
    end

    // Accepted-response counter; stops at NUM_VEC because RUN is left on that beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt <= '0;
        end else if (start_ok) begin
            vec_cnt <= '0;
        end else if (accept) begin
            vec_cnt <= vec_cnt + 1'b1;
        end
    end

    // Verdict captured during CHECK; held through DONE until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass <= 1'b0;
        end else if (start_ok) begin
            pass <= 1'b0;
        end else if (state_q == CHECK) begin
            pass <= (signature == exp_sig);
        end
    end

    case10_misr_core #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (accept),
        .din  ({y2, y1}),
        .seed (SEED),
        .sig  (signature)
    );

`ifdef RESP_TOGGLE_CNT_EN
    logic prev_y1;
    logic prev_y2;

    // Toggle counters: vec_cnt==0 marks the first beat of a run, which has no predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_y1  <= '0;
            tog_y2  <= '0;
            prev_y1 <= 1'b0;
            prev_y2 <= 1'b0;
        end else if (start_ok) begin
            tog_y1  <= '0;
            tog_y2  <= '0;
        end else if (accept) begin
            prev_y1 <= y1;
            prev_y2 <= y2;
            if ((vec_cnt != '0) && (y1 != prev_y1) && (tog_y1 != '1)) begin
                tog_y1 <= tog_y1 + 1'b1;
            end
            if ((vec_cnt != '0) && (y2 != prev_y2) && (tog_y2 != '1)) begin
                tog_y2 <= tog_y2 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_case10_resp_misr.sv
// Bench for case10_resp_misr: default instance driven through a signature scoreboard,
// plus two NUM_VEC=1 instances with fixed seeds for hand-computed signatures.
// Optional RESP_TOGGLE_CNT_EN section checks the toggle counters.
module tb_case10_resp_misr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-parameter instance.
    logic        d_start, d_in_valid, d_in_ready, d_y1, d_y2, d_busy, d_done, d_pass;
    logic [15:0] d_exp_sig, d_signature;
    logic [7:0]  d_vec_cnt;
    // NUM_VEC=1, SEED=0 instance.
    logic        a_start, a_in_valid, a_in_ready, a_y1, a_y2, a_busy, a_done, a_pass;
    logic [15:0] a_exp_sig, a_signature;
    logic [7:0]  a_vec_cnt;
    // NUM_VEC=1, SEED=16'h8000 instance.
    logic        b_start, b_in_valid, b_in_ready, b_y1, b_y2, b_busy, b_done, b_pass;
    logic [15:0] b_exp_sig, b_signature;
    logic [7:0]  b_vec_cnt;
`ifdef RESP_TOGGLE_CNT_EN
    logic [7:0]  d_tog_y1, d_tog_y2, a_tog_y1, a_tog_y2, b_tog_y1, b_tog_y2;
`endif

    case10_resp_misr dut (
        .clk(clk), .rst(rst), .start(d_start), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .y1(d_y1), .y2(d_y2), .exp_sig(d_exp_sig), .busy(d_busy), .done(d_done),
        .pass(d_pass), .signature(d_signature), .vec_cnt(d_vec_cnt)
`ifdef RESP_TOGGLE_CNT_EN
        , .tog_y1(d_tog_y1), .tog_y2(d_tog_y2)
`endif
    );

    case10_resp_misr #(.NUM_VEC(1), .SEED(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .y1(a_y1), .y2(a_y2), .exp_sig(a_exp_sig), .busy(a_busy), .done(a_done),
        .pass(a_pass), .signature(a_signature), .vec_cnt(a_vec_cnt)
`ifdef RESP_TOGGLE_CNT_EN
        , .tog_y1(a_tog_y1), .tog_y2(a_tog_y2)
`endif
    );

    case10_resp_misr #(.NUM_VEC(1), .SEED(16'h8000)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .y1(b_y1), .y2(b_y2), .exp_sig(b_exp_sig), .busy(b_busy), .done(b_done),
        .pass(b_pass), .signature(b_signature), .vec_cnt(b_vec_cnt)
`ifdef RESP_TOGGLE_CNT_EN
        , .tog_y1(b_tog_y1), .tog_y2(b_tog_y2)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference MISR step (POLY 16'h1021, 16-bit).
    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic y1v, input logic y2v);
        logic [15:0] r;
        r = s << 1;
        if (s[15]) r = r ^ 16'h1021;
        r[0] = r[0] ^ y1v;
        r[1] = r[1] ^ y2v;
        return r;
    endfunction

    // Scoreboard state for the default instance.
    logic [15:0] sb_q[$];
    logic [15:0] m_sig;
    int          m_cnt;
    logic        m_run;

    // One cycle on the default instance: predict, push, clock, pop and compare.
    task automatic beat_d(input logic v, input logic y1v, input logic y2v);
        logic acc;
        d_in_valid = v;
        d_y1       = y1v;
        d_y2       = y2v;
        acc        = v & m_run;
        #1;
        check("in_ready", 32'(d_in_ready), 32'(m_run));
        if (acc) begin
            m_sig = misr_next(m_sig, y1v, y2v);
            m_cnt++;
            sb_q.push_back(m_sig);
            if (m_cnt == 16) m_run = 1'b0;
        end
        tick();
        if (sb_q.size() > 0) begin
            check("sb_signature", 32'(d_signature), 32'(sb_q.pop_front()));
        end else begin
            check("hold_signature", 32'(d_signature), 32'(m_sig));
        end
        check("vec_cnt", 32'(d_vec_cnt), 32'(m_cnt));
        d_in_valid = 1'b0;
    endtask

    // Rising edges of done on the default instance.
    int   d_rises = 0;
    logic d_done_prev = 1'b0;
    always @(negedge clk) begin
        if (d_done && !d_done_prev) d_rises++;
        d_done_prev = d_done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        rst = 1'b1;
        d_start = 0; d_in_valid = 0; d_y1 = 0; d_y2 = 0; d_exp_sig = 16'h0;
        a_start = 0; a_in_valid = 0; a_y1 = 0; a_y2 = 0; a_exp_sig = 16'h0001;
        b_start = 0; b_in_valid = 0; b_y1 = 0; b_y2 = 0; b_exp_sig = 16'h1021;
        m_sig = 16'hFFFF; m_cnt = 0; m_run = 1'b0;
        tick();
        tick();
        check("rst_signature", 32'(d_signature), 32'h0000FFFF);
        check("rst_vec_cnt",   32'(d_vec_cnt),   32'd0);
        check("rst_in_ready",  32'(d_in_ready),  32'd0);
        check("rst_busy",      32'(d_busy),      32'd0);
        check("rst_done",      32'(d_done),      32'd0);
        check("rst_pass",      32'(d_pass),      32'd0);
        check("rst_b_sig",     32'(b_signature), 32'h00008000);
        rst = 1'b0;

        // Test 1: SEED=0, one beat y1=1 y2=0.
        a_start = 1; tick(); a_start = 0;
        check("a_busy", 32'(a_busy), 32'd1);
        a_in_valid = 1; a_y1 = 1; a_y2 = 0; tick(); a_in_valid = 0;
        check("a_sig",        32'(a_signature), 32'h00000001);
        check("a_done_early", 32'(a_done),      32'd0);
        check("a_ready_chk",  32'(a_in_ready),  32'd0);
        tick();
        check("a_done", 32'(a_done), 32'd1);
        check("a_pass", 32'(a_pass), 32'd1);

        // Test 2: SEED=16'h8000, one zero beat; matching then mismatching golden value.
        b_start = 1; tick(); b_start = 0;
        b_in_valid = 1; tick(); b_in_valid = 0;
        check("b_sig", 32'(b_signature), 32'h00001021);
        tick();
        check("b_pass_match", 32'(b_pass), 32'd1);
        b_exp_sig = 16'h1020;
        b_start = 1; tick(); b_start = 0;
        check("b_reseed",    32'(b_signature), 32'h00008000);
        check("b_done_clr",  32'(b_done),      32'd0);
        check("b_pass_clr",  32'(b_pass),      32'd0);
        b_in_valid = 1; tick(); b_in_valid = 0;
        tick();
        check("b_done2",         32'(b_done), 32'd1);
        check("b_pass_mismatch", 32'(b_pass), 32'd0);

        // Test 3: in_valid in IDLE is ignored.
        for (int i = 0; i < 5; i++) beat_d(1'b1, 1'b1, 1'b1);
        check("idle_sig", 32'(d_signature), 32'h0000FFFF);

        // Test 4: start together with in_valid (no accept), then 16 accepts on alternate cycles.
        d_start = 1; d_in_valid = 1; tick(); d_start = 0; d_in_valid = 0;
        m_run = 1'b1; m_cnt = 0; m_sig = 16'hFFFF;
        check("start_no_accept_cnt", 32'(d_vec_cnt),   32'd0);
        check("start_no_accept_sig", 32'(d_signature), 32'h0000FFFF);
        guard = 0;
        while (m_run && guard < 100) begin
            beat_d((guard % 2) == 0, 1'($urandom), 1'($urandom));
            guard++;
        end
        check("run_bounded", 32'(m_run), 32'd0);
        d_exp_sig = m_sig;
        check("check_busy", 32'(d_busy), 32'd1);
        check("check_done", 32'(d_done), 32'd0);
        tick();
        check("d_done", 32'(d_done), 32'd1);
        check("d_pass", 32'(d_pass), 32'd1);
        check("d_busy_done", 32'(d_busy), 32'd0);
        for (int i = 0; i < 3; i++) beat_d(1'b1, 1'b1, 1'b0);
        check("done_held", 32'(d_done), 32'd1);
        check("done_once", 32'(d_rises), 32'd1);

        // Test 5: restart from DONE, start in RUN ignored, reset mid-run.
        d_start = 1; tick(); d_start = 0;
        m_run = 1'b1; m_cnt = 0; m_sig = 16'hFFFF;
        check("restart_done", 32'(d_done), 32'd0);
        check("restart_pass", 32'(d_pass), 32'd0);
        check("restart_sig",  32'(d_signature), 32'h0000FFFF);
        for (int i = 0; i < 7; i++) begin
            d_start = (i == 3);
            beat_d(1'b1, 1'($urandom), 1'($urandom));
            d_start = 0;
        end
        check("mid_vec_cnt", 32'(d_vec_cnt), 32'd7);
        rst = 1; tick(); rst = 0;
        m_run = 1'b0; m_cnt = 0; m_sig = 16'hFFFF;
        check("mid_rst_cnt",   32'(d_vec_cnt),   32'd0);
        check("mid_rst_sig",   32'(d_signature), 32'h0000FFFF);
        check("mid_rst_busy",  32'(d_busy),      32'd0);
        check("mid_rst_ready", 32'(d_in_ready),  32'd0);
        check("mid_rst_done",  32'(d_done),      32'd0);

`ifdef RESP_TOGGLE_CNT_EN
        // Test 6: y1 0,1,1,0 and y2 held at 1.
        d_start = 1; tick(); d_start = 0;
        m_run = 1'b1; m_cnt = 0; m_sig = 16'hFFFF;
        check("tog_clr_y1", 32'(d_tog_y1), 32'd0);
        beat_d(1'b1, 1'b0, 1'b1);
        beat_d(1'b1, 1'b1, 1'b1);
        beat_d(1'b1, 1'b1, 1'b1);
        beat_d(1'b1, 1'b0, 1'b1);
        check("tog_y1", 32'(d_tog_y1), 32'd2);
        check("tog_y2", 32'(d_tog_y2), 32'd0);
        rst = 1; tick(); rst = 0;
        check("tog_rst_y1", 32'(d_tog_y1), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
